axi_stream_extract_header: RTL

Receive-side counterpart of the header-insert block. It strips the leading byte_extract_cnt bytes of each AXI-Stream packet and presents them on a separate header port. The remaining payload is realigned so that every output beat is full (MSB-first), with a left-aligned keep on the last beat only. It sits between the link-side stream and the payload consumer, and uses the same byte ordering as the insert block.

---
 rtl/axi_stream_extract_header_if.sv | 41 ++++
 rtl/axi_stream_extract_header.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_extract_header_if.sv
// Stream bundle for the header-extract block: link-side input stream,
// header output port and realigned payload output port.
interface axi_stream_extract_header_if #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
  logic                    valid_in;
  logic [DATA_WD-1:0]      data_in;
  logic [DATA_BYTE_WD-1:0] keep_in;
  logic                    last_in;
  logic                    ready_in;
  logic [BYTE_CNT_WD:0]    byte_extract_cnt;

  logic                    valid_header;
  logic [DATA_WD-1:0]      data_header;
  logic [DATA_BYTE_WD-1:0] keep_header;
  logic                    ready_header;

  logic                    valid_out;
  logic [DATA_WD-1:0]      data_out;
  logic [DATA_BYTE_WD-1:0] keep_out;
  logic                    last_out;
  logic                    ready_out;

  // Producer / consumer side (drives the input stream, accepts the outputs).
  modport master (
    output valid_in, data_in, keep_in, last_in, byte_extract_cnt,
    output ready_header, ready_out,
    input  ready_in, valid_header, data_header, keep_header,
    input  valid_out, data_out, keep_out, last_out
  );

  // Header-extract block side.
  modport slave (
    input  valid_in, data_in, keep_in, last_in, byte_extract_cnt,
    input  ready_header, ready_out,
    output ready_in, valid_header, data_header, keep_header,
    output valid_out, data_out, keep_out, last_out
  );
endinterface

// File: rtl/axi_stream_extract_header.sv
// Strips the leading N bytes of each packet onto a header port and realigns
// the remaining payload so every output beat is full (MSB-first), with a
// left-aligned keep only on the last beat. N = 0 passes packets through.
module axi_stream_extract_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input logic                         clk,
  input logic                         rst,
  axi_stream_extract_header_if.slave  bus
);
  localparam int CW = BYTE_CNT_WD + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_BODY, ST_FLUSH} state_t;

  state_t                  r_state, w_state_nxt;
  logic [CW-1:0]           r_n, w_n_nxt;                 // clamped header length
  logic [CW-1:0]           r_flush_cnt, w_flush_cnt_nxt; // bytes held for FLUSH
  logic [DATA_WD-1:0]      r_res, w_res_nxt;             // residual, left-aligned

  logic                    r_valid_out, r_last_out;
  logic [DATA_WD-1:0]      r_data_out;
  logic [DATA_BYTE_WD-1:0] r_keep_out;
  logic                    r_valid_header;
  logic [DATA_WD-1:0]      r_data_header;
  logic [DATA_BYTE_WD-1:0] r_keep_header;

  logic                    w_out_free, w_hdr_free, w_ready_in, w_acc;
  logic                    w_out_load, w_out_last, w_hdr_load;
  logic [DATA_WD-1:0]      w_out_data, w_hdr_data, w_full;
  logic [DATA_BYTE_WD-1:0] w_out_keep, w_hdr_keep;
  int                      w_k, w_n, w_r;

  // c valid bytes packed toward the MSB end.
  function automatic logic [DATA_BYTE_WD-1:0] left_mask(input int c);
    logic [DATA_BYTE_WD-1:0] m;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[i] = (i >= DATA_BYTE_WD - c);
    return m;
  endfunction

  // c valid bytes packed toward the LSB end.
  function automatic logic [DATA_BYTE_WD-1:0] right_mask(input int c);
    logic [DATA_BYTE_WD-1:0] m;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[i] = (i < c);
    return m;
  endfunction

  function automatic logic [DATA_WD-1:0] expand(input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] m;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  function automatic int popcount(input logic [DATA_BYTE_WD-1:0] k);
    int c;
    c = 0;
    for (int i = 0; i < DATA_BYTE_WD; i++) c += int'(k[i]);
    return c;
  endfunction

  assign w_out_free = !r_valid_out || bus.ready_out;
  assign w_hdr_free = !r_valid_header || bus.ready_header;
  // A new packet also needs the header slot, even when N turns out to be 0.
  assign w_ready_in = !rst && (((r_state == ST_IDLE) && w_out_free && w_hdr_free) ||
                               ((r_state == ST_BODY) && w_out_free));
  assign w_acc      = bus.valid_in && w_ready_in;

  // Next-state and datapath decode for the accepted beat.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
    w_state_nxt     = r_state;
    w_n_nxt         = r_n;
    w_flush_cnt_nxt = r_flush_cnt;
    w_res_nxt       = r_res;
    w_out_load      = 1'b0;
    w_out_data      = '0;
    w_out_keep      = '0;
    w_out_last      = 1'b0;
    w_hdr_load      = 1'b0;
    w_hdr_data      = '0;
    w_hdr_keep      = '0;
    w_k             = popcount(bus.keep_in);
    w_n             = int'(r_n);
    w_r             = DATA_BYTE_WD - int'(r_n);
    w_full          = r_res | (bus.data_in >> (8 * w_r));

    case (r_state)
      ST_IDLE: begin
        if (w_acc) begin
          w_n     = (int'(bus.byte_extract_cnt) > DATA_BYTE_WD) ?
                    DATA_BYTE_WD : int'(bus.byte_extract_cnt);
          w_r     = DATA_BYTE_WD - w_n;
          w_n_nxt = CW'(w_n);
          if (w_n == 0) begin
            w_out_load = 1'b1;
            w_out_data = bus.data_in;
            w_out_keep = bus.keep_in;
            w_out_last = bus.last_in;
            if (!bus.last_in) w_state_nxt = ST_BODY;
          end else begin
            w_hdr_load = 1'b1;
            if (bus.last_in && (w_k <= w_n)) begin
              // Short single-beat packet: the header takes all k bytes.
              w_hdr_data = bus.data_in >> (8 * (DATA_BYTE_WD - w_k));
              w_hdr_keep = right_mask(w_k);
            end else begin
              w_hdr_data = bus.data_in >> (8 * w_r);
              w_hdr_keep = right_mask(w_n);
              if (bus.last_in) begin
                w_out_load = 1'b1;
                w_out_keep = left_mask(w_k - w_n);
                w_out_data = (bus.data_in << (8 * w_n)) & expand(w_out_keep);
                w_out_last = 1'b1;
              end else begin
                w_res_nxt   = bus.data_in << (8 * w_n);
                w_state_nxt = ST_BODY;
              end
            end
          end
        end
      end

      ST_BODY: begin
        if (w_acc) begin
          w_out_load = 1'b1;
          if (w_n == 0) begin
            w_out_data = bus.data_in;
            w_out_keep = bus.keep_in;
            w_out_last = bus.last_in;
            if (bus.last_in) w_state_nxt = ST_IDLE;
          end else if (!bus.last_in) begin
            w_out_data = w_full;
            w_out_keep = '1;
            w_res_nxt  = bus.data_in << (8 * w_n);
          end else if (w_k <= w_n) begin
            w_out_keep  = left_mask(w_r + w_k);
            w_out_data  = w_full & expand(w_out_keep);
            w_out_last  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            // Residual plus tail overflow one beat: hold the surplus for FLUSH.
            w_out_data      = w_full;
            w_out_keep      = '1;
            w_res_nxt       = (bus.data_in << (8 * w_n)) & expand(left_mask(w_k - w_n));
            w_flush_cnt_nxt = CW'(w_k - w_n);
            w_state_nxt     = ST_FLUSH;
          end
        end
      end

      ST_FLUSH: begin
        if (w_out_free) begin
          w_out_load  = 1'b1;
          w_out_data  = r_res;
          w_out_keep  = left_mask(int'(r_flush_cnt));
          w_out_last  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so all registers update together.
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Output slots, residual buffer and per-packet bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_n            <= '0;
      r_flush_cnt    <= '0;
      r_res          <= '0;
      r_valid_out    <= 1'b0;
      r_data_out     <= '0;
      r_keep_out     <= '0;
      r_last_out     <= 1'b0;
      r_valid_header <= 1'b0;
      r_data_header  <= '0;
      r_keep_header  <= '0;
    end else begin
      r_n         <= w_n_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_res       <= w_res_nxt;
      if (w_out_free) r_valid_out <= w_out_load;
      if (w_out_load) begin
        r_data_out <= w_out_data;
        r_keep_out <= w_out_keep;
        r_last_out <= w_out_last;
      end
      if (w_hdr_free) r_valid_header <= w_hdr_load;
      if (w_hdr_load) begin
        r_data_header <= w_hdr_data;
        r_keep_header <= w_hdr_keep;
      end
    end
  end

  assign bus.ready_in     = w_ready_in;
  assign bus.valid_out    = r_valid_out;
  assign bus.data_out     = r_data_out;
  assign bus.keep_out     = r_keep_out;
  assign bus.last_out     = r_last_out;
  assign bus.valid_header = r_valid_header;
  assign bus.data_header  = r_data_header;
  assign bus.keep_header  = r_keep_header;
endmodule
